// File: rtl/modn_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped parallel load, terminal count and wrap pulse.
// Define MODN_COUNTER_SATURATE_EN to make counting stop at the ends instead of wrapping.
module modn_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("modn_updown_counter: MODULUS out of range for WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count_q == MAX_VAL);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Boundary is detected before the +/-1, so MODULUS = 2**WIDTH never overflows.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef MODN_COUNTER_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
`ifdef MODN_COUNTER_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;
    assign tc   = en & (up ? at_max : at_zero);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: directed steps plus random traffic against an
// arithmetic reference model; also checks a two-stage cascade built from tc.
module tb_modn_updown_counter;

    localparam int M  = 10;
    localparam int MC = 16;

    logic       clk = 1'b0;
    logic       rst, en, up, clr, load;
    logic [3:0] load_val;
    wire  [3:0] q;
    wire        tc, wrap;

    logic       c_rst;
    wire  [3:0] lo_q, hi_q;
    wire        lo_tc, hi_tc, lo_wrap, hi_wrap;

    int tests  = 0;
    int failed = 0;

    int m_cur;
    bit m_wrap;
    int c_lo, c_hi;
    bit c_lo_w, c_hi_w;

    always #5 clk = ~clk;

    modn_updown_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(MC)) u_lo (
        .clk(clk), .rst(c_rst), .en(1'b1), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(MC)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: next count and wrap flag for one clock edge, straight from the counting rules.
    task automatic model_step(input int m, input int cur, input bit e, input bit u, input bit c,
                              input bit l, input int lv, output int nxt, output bit w);
        nxt = cur;
        w   = 1'b0;
        if (c)      nxt = 0;
        else if (l) nxt = (lv >= m) ? m - 1 : lv;
        else if (e) begin
`ifdef MODN_COUNTER_SATURATE_EN
            if (u) nxt = (cur == m - 1) ? cur : cur + 1;
            else   nxt = (cur == 0) ? 0 : cur - 1;
`else
            if (u) begin nxt = (cur + 1) % m;     w = (cur == m - 1); end
            else   begin nxt = (cur + m - 1) % m; w = (cur == 0);     end
`endif
        end
    endtask

    function automatic bit model_tc(input int m, input int cur, input bit e, input bit u);
        return e && (u ? (cur == m - 1) : (cur == 0));
    endfunction

    // Apply inputs, check tc before the edge, clock once, check q/wrap after it.
    task automatic do_cycle(input string tag, input bit e, input bit u, input bit c,
                            input bit l, input int lv);
        int nxt;
        bit w;
        en = e; up = u; clr = c; load = l; load_val = 4'(lv);
        #1;
        check({tag, ".tc"}, 32'(tc), 32'(model_tc(M, m_cur, e, u)));
        model_step(M, m_cur, e, u, c, l, lv, nxt, w);
        @(posedge clk);
        #1;
        m_cur  = nxt;
        m_wrap = w;
        check({tag, ".q"}, 32'(q), 32'(m_cur));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        $display("[TB] %s en=%0d up=%0d clr=%0d load=%0d lv=%0d -> q=%0d wrap=%0d tc=%0d",
                 tag, e, u, c, l, lv, q, wrap, tc);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        c_rst = 1'b1;
        m_cur = 0; m_wrap = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset.q", 32'(q), 32'd0);
        check("reset.wrap", 32'(wrap), 32'd0);

        // Controls ignored while rst is held
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold.q", 32'(q), 32'd0);
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_release_idle.q", 32'(q), 32'd0);

        // Count up 12 clocks: 1..9,0,1,2 (wrap after 9->0)
        for (int i = 0; i < 12; i++) do_cycle("up_seq", 1, 1, 0, 0, 0);

        // Clear, then count down through 0 -> 9
        do_cycle("clr", 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle("down_seq", 1, 0, 0, 0, 0);

        // Hold with en=0, tc must stay low even at 0
        do_cycle("clr2", 0, 0, 1, 0, 0);
        do_cycle("hold_en0_down", 0, 0, 0, 0, 0);
        do_cycle("hold_en0_up", 0, 1, 0, 0, 0);

        // Clamped load, in-range load, clr beats load, load beats en
        do_cycle("load13", 0, 1, 0, 1, 13);
        do_cycle("load5", 0, 1, 0, 1, 5);
        do_cycle("clr_and_load", 1, 1, 1, 1, 5);
        do_cycle("load_over_en", 1, 1, 0, 1, 8);
        do_cycle("load_at_wrap", 1, 1, 0, 1, 9);
        do_cycle("load_blocks_wrap", 1, 1, 0, 1, 2);

        // Direction change takes effect on the same edge
        do_cycle("dir_up", 1, 1, 0, 0, 0);
        do_cycle("dir_down", 1, 0, 0, 0, 0);

        // Mid-cycle reset at q=6, then resume 1,2
        do_cycle("load6", 0, 1, 0, 1, 6);
        en = 1'b1; up = 1'b1; load = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("midrst.q", 32'(q), 32'd0);
        check("midrst.wrap", 32'(wrap), 32'd0);
        m_cur = 0; m_wrap = 1'b0;
        #1 rst = 1'b0;
        do_cycle("resume1", 1, 1, 0, 0, 0);
        do_cycle("resume2", 1, 1, 0, 0, 0);

        // Reset across an edge that would have wrapped 9->0: no wrap pulse afterwards
        do_cycle("load9", 0, 1, 0, 1, 9);
        en = 1'b1; up = 1'b1; load = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wrap.q", 32'(q), 32'd0);
        check("abort_wrap.wrap", 32'(wrap), 32'd0);
        m_cur = 0; m_wrap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_cycle("after_abort", 0, 1, 0, 0, 0);

        // Random traffic against the model, range check on every cycle
        for (int i = 0; i < 300; i++) begin
            do_cycle("rand", ($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
                     ($urandom % 10) == 0, int'($urandom % 16));
            check("rand.range", 32'(q < 4'(M)), 32'd1);
        end

        // Cascade: lower stage counts every clock, upper stage enabled by lower tc
        c_lo = 0; c_hi = 0;
        @(negedge clk);
        check("casc.reset", 32'({hi_q, lo_q}), 32'd0);
        c_rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            int lo_n, hi_n;
            bit lo_t;
            lo_t = model_tc(MC, c_lo, 1'b1, 1'b1);
            check("casc.lo_tc", 32'(lo_tc), 32'(lo_t));
            check("casc.hi_tc", 32'(hi_tc), 32'(model_tc(MC, c_hi, lo_t, 1'b1)));
            model_step(MC, c_hi, lo_t, 1'b1, 1'b0, 1'b0, 0, hi_n, c_hi_w);
            model_step(MC, c_lo, 1'b1, 1'b1, 1'b0, 1'b0, 0, lo_n, c_lo_w);
            @(posedge clk);
            #1;
            c_lo = lo_n; c_hi = hi_n;
            check("casc.count", 32'({hi_q, lo_q}), 32'(c_hi * MC + c_lo));
            check("casc.lo_wrap", 32'(lo_wrap), 32'(c_lo_w));
            check("casc.hi_wrap", 32'(hi_wrap), 32'(c_hi_w));
            if ((i % 16) == 15 || i >= 254)
                $display("[TB] casc step %0d -> hi=%0d lo=%0d hi_wrap=%0d", i, hi_q, lo_q, hi_wrap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
